sha1_msg_schedule: RTL and testbench

SHA1_MSG_SCHEDULE -- requirements
Module: sha1_msg_schedule

---
 rtl/sha1_msg_schedule_pkg.sv | 49 ++++
 rtl/sha1_msg_schedule.sv | 98 +++++++++
 tb/tb_sha1_msg_schedule.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha1_msg_schedule_pkg.sv
// Shared definitions for the SHA-1 message schedule: FSM states, round constants,
// round-function select encodings and small word helpers.
package sha1_msg_schedule_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        QF_CH   = 2'b00,
        QF_PAR0 = 2'b01,
        QF_MAJ  = 2'b10,
        QF_PAR1 = 2'b11
    } quad_funct_t;

    localparam int          WINDOW_WORDS = 16;
    localparam logic [6:0]  LAST_ROUND   = 7'd79;

    localparam logic [31:0] K_CH   = 32'h5A82_7999;
    localparam logic [31:0] K_PAR0 = 32'h6ED9_EBA1;
    localparam logic [31:0] K_MAJ  = 32'h8F1B_BCDC;
    localparam logic [31:0] K_PAR1 = 32'hCA62_C1D6;

    function automatic quad_funct_t quad_of_round(input logic [6:0] t);
        if (t < 7'd20)      return QF_CH;
        else if (t < 7'd40) return QF_PAR0;
        else if (t < 7'd60) return QF_MAJ;
        else                return QF_PAR1;
    endfunction

    function automatic logic [31:0] k_of_quad(input quad_funct_t q);
        logic [31:0] k;
        case (q)
            QF_CH:   k = K_CH;
            QF_PAR0: k = K_PAR0;
            QF_MAJ:  k = K_MAJ;
            QF_PAR1: k = K_PAR1;
            default: k = K_CH;
        endcase
        return k;
    endfunction

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

endpackage

// File: rtl/sha1_msg_schedule.sv
// SHA-1 message schedule: expands a 512-bit block into 80 W[t]+K(t) words through a
// 16-word sliding window, one word per downstream handshake.
module sha1_msg_schedule
    import sha1_msg_schedule_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic         wk_ready,
    output logic [31:0]  wk,
    output logic         wk_valid,
    output logic [1:0]   quad_funct,
    output logic [6:0]   round,
    output logic         busy,
    output logic         done
);

    state_t      state_q, state_d;
    logic [6:0]  round_q, round_d;
    logic [31:0] window_q [WINDOW_WORDS];
    logic [31:0] window_d [WINDOW_WORDS];
    logic        handshake;
    logic [31:0] w_new;
    quad_funct_t quad;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it
        // unassigned; that is what keeps this block from inferring latches.
        state_d   = state_q;
        round_d   = round_q;
        window_d  = window_q;
        handshake = (state_q == ST_RUN) && wk_ready;
        w_new     = rotl1(window_q[13] ^ window_q[8] ^ window_q[2] ^ window_q[0]);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int i = 0; i < WINDOW_WORDS; i++) begin
                        window_d[i] = block_in[511 - 32*i -: 32];
                    end
                    round_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (handshake) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = ST_DONE;
                    end else begin
                        // Oldest word leaves at index 0; the freshly expanded word enters at 15.
                        for (int i = 0; i < WINDOW_WORDS - 1; i++) begin
                            window_d[i] = window_q[i + 1];
                        end
                        window_d[WINDOW_WORDS - 1] = w_new;
                        round_d = round_q + 7'd1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples the
        // pre-edge value of its neighbours, exactly as the hardware does.
        if (reset) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            // NOTE: the window is a small register array, not a RAM, so clearing it on
            // reset is cheap and leaves no stale message words behind after an abort.
            for (int i = 0; i < WINDOW_WORDS; i++) begin
                window_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            window_q <= window_d;
        end
    end

    always_comb begin
        quad       = quad_of_round(round_q);
        wk_valid   = (state_q == ST_RUN);
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        wk         = '0;
        round      = '0;
        quad_funct = '0;
        if (wk_valid) begin
            wk         = window_q[0] + k_of_quad(quad);
            round      = round_q;
            quad_funct = quad;
        end
    end

endmodule

// File: tb/tb_sha1_msg_schedule.sv
// Scoreboard bench for sha1_msg_schedule: stimulus pushes the 80 expected words per block,
// a negedge monitor pops and compares on every handshake.
module tb_sha1_msg_schedule;

    logic         clk;
    logic         reset;
    logic         start;
    logic [511:0] block_in;
    logic         wk_ready;
    logic [31:0]  wk;
    logic         wk_valid;
    logic [1:0]   quad_funct;
    logic [6:0]   round;
    logic         busy;
    logic         done;

    typedef struct {
        logic [6:0]  rnd;
        logic [31:0] wk;
        logic [1:0]  quad;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   rand_ready = 0;
    bit   abc_active = 0;

    localparam logic [511:0] ABC_BLOCK = {32'h6162_6380, 448'h0, 32'h0000_0018};

    sha1_msg_schedule dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .block_in   (block_in),
        .wk_ready   (wk_ready),
        .wk         (wk),
        .wk_valid   (wk_valid),
        .quad_funct (quad_funct),
        .round      (round),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference schedule written from the textbook recurrence over a full 80-word array.
    task automatic push_expected(input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] x;
        logic [31:0] k;
        exp_t        e;
        for (int t = 0; t < 16; t++) w[t] = 32'(blk >> (32 * (15 - t)));
        for (int t = 16; t < 80; t++) begin
            x    = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
            w[t] = {x[30:0], x[31]};
        end
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      k = 32'h5A82_7999;
            else if (t < 40) k = 32'h6ED9_EBA1;
            else if (t < 60) k = 32'h8F1B_BCDC;
            else             k = 32'hCA62_C1D6;
            e.rnd  = 7'(t);
            e.quad = 2'(t / 20);
            e.wk   = w[t] + k;
            sb_q.push_back(e);
        end
    endtask

    // Downstream ready: always high, or a coin flip each cycle.
    initial begin
        wk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            wk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compares every handshake against the scoreboard and polices idle/stall/done.
    initial begin
        bit          expect_done;
        bit          prev_stall;
        logic [31:0] prev_wk;
        logic [6:0]  prev_round;
        logic [1:0]  prev_quad;
        exp_t        e;
        expect_done = 0;
        prev_stall  = 0;
        prev_wk     = '0;
        prev_round  = '0;
        prev_quad   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                expect_done = 0;
                prev_stall  = 0;
            end else begin
                if (expect_done) begin
                    check("done_pulse", 32'(done), 32'd1);
                    check("done_busy", 32'(busy), 32'd1);
                    expect_done = 0;
                end else if (done) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end
                if (prev_stall) begin
                    if (wk_valid) begin
                        check("stall_hold_wk", wk, prev_wk);
                        check("stall_hold_round", 32'(round), 32'(prev_round));
                        check("stall_hold_quad", 32'(quad_funct), 32'(prev_quad));
                    end else begin
                        check("stall_dropped_valid", 32'(wk_valid), 32'd1);
                    end
                end
                if (wk_valid) begin
                    if (wk_ready) begin
                        if (sb_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_output: got round %0d expected no output", round);
                        end else begin
                            e = sb_q.pop_front();
                            check("sb_round", 32'(round), 32'(e.rnd));
                            check("sb_wk", wk, e.wk);
                            check("sb_quad", 32'(quad_funct), 32'(e.quad));
                            if (abc_active && e.rnd == 7'd0)  check("abc_t0_wk", wk, 32'hBBE4_DD19);
                            if (abc_active && e.rnd == 7'd16) check("abc_t16_wk", wk, 32'h1D47_4099);
                            if (e.rnd == 7'd79) expect_done = 1;
                        end
                    end
                end else begin
                    check("idle_wk", wk, 32'd0);
                    check("idle_round", 32'(round), 32'd0);
                    check("idle_quad", 32'(quad_funct), 32'd0);
                end
                prev_stall = wk_valid && !wk_ready;
                prev_wk    = wk;
                prev_round = round;
                prev_quad  = quad_funct;
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_wk"}, wk, 32'd0);
        check({tag, "_wk_valid"}, 32'(wk_valid), 32'd0);
        check({tag, "_round"}, 32'(round), 32'd0);
        check({tag, "_quad"}, 32'(quad_funct), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Issues one block; caller guarantees the DUT is in IDLE at the next edge.
    task automatic run_block(input logic [511:0] blk, input bit rnd, input bit inj,
                             input int rst_at, input bit chk_lat);
        int cyc;
        bit fin;
        push_expected(blk);
        rand_ready = rnd;
        block_in   = blk;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        block_in = '0;
        cyc      = 1;
        check("first_valid", 32'(wk_valid), 32'd1);
        check("first_round", 32'(round), 32'd0);
        fin = 0;
        while (!fin) begin
            if (done) begin
                fin = 1;
                if (chk_lat) check("done_latency", 32'(cyc), 32'd81);
                check("sb_drained", 32'(sb_q.size()), 32'd0);
                if (inj) begin
                    start = 1'b1;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                    check("start_in_done_ignored", 32'(busy), 32'd0);
                end
            end else if (cyc >= 2000) begin
                fin = 1;
                total++;
                bad++;
                $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
            end else if (rst_at >= 0 && wk_valid && 32'(round) == 32'(rst_at)) begin
                fin   = 1;
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                sb_q.delete();
                check_reset_state("midrun_reset");
                repeat (5) @(posedge clk);
                #1;
                check("post_reset_idle_busy", 32'(busy), 32'd0);
            end else begin
                start = inj && wk_valid && (round == 7'd40 || round == 7'd79);
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start      = 1'b0;
        rand_ready = 0;
    endtask

    initial begin
        logic [511:0] blk2;
        reset    = 1'b1;
        start    = 1'b0;
        block_in = '0;
        for (int i = 0; i < 16; i++) blk2[511 - 32*i -: 32] = 32'h9E37_79B9 * 32'(i + 1);

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // "abc" block, ready always high, latency and hand-computed words.
        abc_active = 1;
        run_block(ABC_BLOCK, 1'b0, 1'b0, -1, 1'b1);

        // Back-to-back: start in the IDLE cycle right after done, random ready.
        @(posedge clk);
        #1;
        run_block(ABC_BLOCK, 1'b1, 1'b0, -1, 1'b0);

        // Start pulses at t=40, coincident with the t=79 handshake, and in DONE.
        repeat (3) @(posedge clk);
        #1;
        run_block(ABC_BLOCK, 1'b0, 1'b1, -1, 1'b1);

        // Reset at t=50 abandons the block.
        repeat (2) @(posedge clk);
        #1;
        run_block(ABC_BLOCK, 1'b0, 1'b0, 50, 1'b0);

        // Full run of a different block after the abort.
        abc_active = 0;
        run_block(blk2, 1'b0, 1'b0, -1, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
